// File: rtl/flag_ctrl.sv
// Carry/zero/interrupt-enable flag arbitration with interrupt entry/return sequencing.
// Optional shadow save/restore of C/Z on interrupt entry/return: define SHADOW_FLAGS_EN.
module flag_ctrl (
    input  logic clk,
    input  logic reset_n,
    input  logic alu_c,
    input  logic alu_z,
    input  logic c_ld,
    input  logic z_ld,
    input  logic c_set,
    input  logic c_clr,
    input  logic i_set,
    input  logic i_clr,
    input  logic reti,
    input  logic reti_ie,
    input  logic intr,
    input  logic boundary,
    output logic intr_take,
    output logic c_flag,
    output logic z_flag,
    output logic i_flag,
    output logic shad_c,
    output logic shad_z,
    output logic in_isr
);

    typedef enum logic [1:0] {StIdle, StPending, StEnter, StActive} state_e;

    state_e r_state, w_state_nxt;
    logic   r_c, r_z, r_i;
    logic   w_c_nxt, w_z_nxt, w_i_nxt;
    logic   w_entry, w_ret, w_restore;
    logic   w_shad_c, w_shad_z;

    // PENDING->ENTER edge; a same-cycle CLI cancels the request instead
    assign w_entry = (r_state == StPending) && !i_clr && boundary;
    assign w_ret   = (r_state == StActive) && reti;

`ifdef SHADOW_FLAGS_EN
    logic r_shad_c, r_shad_z;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shad_c <= 1'b0;
            r_shad_z <= 1'b0;
        end else if (w_entry) begin
            r_shad_c <= r_c;
            r_shad_z <= r_z;
        end
    end

    assign w_shad_c  = r_shad_c;
    assign w_shad_z  = r_shad_z;
    assign w_restore = w_ret;
`else
    assign w_shad_c  = 1'b0;
    assign w_shad_z  = 1'b0;
    assign w_restore = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:    if (intr && r_i) w_state_nxt = StPending;
            StPending: begin
                if (i_clr)         w_state_nxt = StIdle;
                else if (boundary) w_state_nxt = StEnter;
            end
            StEnter:   w_state_nxt = StActive;
            StActive:  if (reti) w_state_nxt = StIdle;
            default:   w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        w_c_nxt = r_c;
        w_z_nxt = r_z;
        w_i_nxt = r_i;

        if (w_restore)  w_c_nxt = w_shad_c;
        else if (c_clr) w_c_nxt = 1'b0;
        else if (c_set) w_c_nxt = 1'b1;
        else if (c_ld)  w_c_nxt = alu_c;

        if (w_restore)  w_z_nxt = w_shad_z;
        else if (z_ld)  w_z_nxt = alu_z;

        // I is held at 0 from the entry edge through ENTER; return always wins
        if (w_ret)                             w_i_nxt = reti_ie;
        else if (w_entry || r_state == StEnter) w_i_nxt = 1'b0;
        else if (i_clr)                        w_i_nxt = 1'b0;
        else if (i_set)                        w_i_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_c     <= 1'b0;
            r_z     <= 1'b0;
            r_i     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_c     <= w_c_nxt;
            r_z     <= w_z_nxt;
            r_i     <= w_i_nxt;
        end
    end

    assign c_flag    = r_c;
    assign z_flag    = r_z;
    assign i_flag    = r_i;
    assign shad_c    = w_shad_c;
    assign shad_z    = w_shad_z;
    assign intr_take = (r_state == StEnter);
    assign in_isr    = (r_state == StEnter) || (r_state == StActive);

endmodule

// File: doc/flag_ctrl.md
# flag_ctrl

Flag and interrupt sequencer for the MCU datapath. Owns the carry (C), zero (Z) and interrupt-enable (I) flags plus the shadow C/Z copies. Arbitrates per-cycle flag writes from the ALU and the control unit, and runs the interrupt entry/return sequence: latch request, wait for an instruction boundary, save flags, signal the control unit, then restore on return. Sits between the control unit, the ALU and the external interrupt line.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- alu_c, alu_z  in  1 each  ALU carry/zero results
- c_ld, z_ld  in  1 each  load C/Z from alu_c/alu_z
- c_set, c_clr  in  1 each  force C to 1/0 (SEC/CLC)
- i_set, i_clr  in  1 each  SEI/CLI
- reti  in  1  return-from-interrupt strobe
- reti_ie  in  1  I value after return (RETIE=1, RETID=0)
- intr  in  1  external interrupt request, level
- boundary  in  1  instruction-boundary strobe from control unit (fetch state)
- intr_take  out  1  one-cycle pulse: control unit must vector to ISR
- c_flag, z_flag, i_flag  out  1 each  live flags
- shad_c, shad_z  out  1 each  shadow flags
- in_isr  out  1  high while state is ENTER or ACTIVE

## Operation
- Reset (async, reset_n=0): all flags, shadows and intr_take = 0; state = IDLE; in_isr = 0.
- Per-flag priority, C: clr > set > ld > hold. Z: ld > hold. I: i_clr > i_set > hold.
- FSM states:
  - IDLE -> PENDING when intr=1 and i_flag=1.
  - PENDING -> IDLE on i_clr (CLI cancels the request). Otherwise PENDING -> ENTER on boundary=1. PENDING persists if intr drops.
  - ENTER lasts one cycle -> ACTIVE.
  - ACTIVE -> IDLE on reti.
- Entry edge (PENDING->ENTER):
  - shad_c/shad_z capture the registered c_flag/z_flag (pre-update values).
  - I is forced to 0, overriding i_set.
  - Any same-cycle C/Z update still applies to the live flags.
- ENTER: intr_take=1 (Moore output).
- ACTIVE:
  - intr is ignored; there is no nesting, even if i_set is asserted.
  - On reti: C<=shad_c, Z<=shad_z, I<=reti_ie. These override every same-cycle ld/set/clr/i_set/i_clr.
- reti in IDLE, PENDING or ENTER is ignored. Normal flag updates still apply.
- i_set/i_clr in ENTER are ignored; I stays 0.

## Timing
- All outputs are registered, except in_isr and intr_take, which decode the registered state.
- Flag writes take effect at the next rising edge (latency 1).
- Minimum entry latency:
  - intr high at edge N gives PENDING at N+1.
  - boundary high during cycle N+1 gives ENTER (intr_take=1) at N+2.
  - ACTIVE at N+3.
- intr_take is exactly one cycle wide per accepted interrupt.
- reti in ACTIVE: restored flags are visible after the next edge; state is IDLE at that same edge.
- A new request can then be accepted if intr=1 and the restored I=1: PENDING one edge later.
- Reset asserted mid-sequence (any state) returns immediately to IDLE with all flags 0; the shadow contents are lost.

## Configuration
- SHADOW_FLAGS_EN defined: shadow registers and save/restore behave as above.
- SHADOW_FLAGS_EN undefined:
  - No shadow registers; shad_c/shad_z tie to 0.
  - Entry does not save flags.
  - reti in ACTIVE leaves C/Z under normal priority (ld/set/clr apply) and only sets I<=reti_ie.
  - FSM and intr_take timing are unchanged.

## Test plan
- Priority:
  - c_clr=c_set=c_ld=1, alu_c=1 -> c_flag=0.
  - c_set=c_ld=1, alu_c=0 -> c_flag=1.
  - i_clr=i_set=1 -> i_flag=0.
- Entry:
  - Setup: C=1, Z=0, I=1, intr=1 at edge 0; boundary=1 during cycle 1.
  - At edge 2: intr_take=1 for exactly one cycle, shad_c=1, shad_z=0, i_flag=0, in_isr=1.
- Cancel: I=1, intr pulse moves the FSM to PENDING, then i_clr=1 with boundary=0 -> IDLE, intr_take never asserts.
- Return:
  - Setup: in ACTIVE with C=0/Z=1 modified by ALU, shadows 1/0.
  - Stimulus: reti=1, reti_ie=1, c_ld=1, alu_c=0.
  - Next edge: c_flag=1, z_flag=0, i_flag=1, state IDLE.
  - With SHADOW_FLAGS_EN undefined: c_flag=0, z_flag=1, i_flag=1.
- No nesting / stray return:
  - intr=1 plus i_set in ACTIVE -> no intr_take.
  - reti in IDLE with C=1 -> C stays 1, I unchanged.
- Async reset:
  - Stimulus: reset_n low mid-cycle during ENTER.
  - Outputs go to 0 immediately without a clock edge; state is IDLE after release.
